// File: rtl/rf_read_arbiter.sv
// Four-way arbiter for a single 64-bit register-file read port.
// Round-robin with bounded bursts; data and steering select are registered.
module rf_read_arbiter #(
  parameter int NREQ      = 4,
  parameter int AW        = 5,
  parameter int DW        = 64,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0][AW-1:0] addr,
  output logic [NREQ-1:0]         gnt,
  output logic [AW-1:0]           rf_rd_addr,
  input  logic [DW-1:0]           rf_rd_data,
  output logic [DW-1:0]           rdata,
  output logic [NREQ-1:0]         rvalid,
  output logic [1:0]              sel
);

  localparam logic [3:0] CLIM = 4'(MAX_BURST - 1);

  logic [1:0] ptr;
  logic [1:0] owner;
  logic       own_v;
  logic [3:0] cnt;

  logic       own_req;
  logic       cont;
  logic       rot;
  logic       sole;
  logic       win_v;
  logic [1:0] rwin;
  logic [1:0] win;
  logic [1:0] idx;

  always_comb begin
    own_req = own_v & req[owner];
    cont    = own_req & (cnt < CLIM);
    rot     = 1'b0;
    rwin    = '0;
    idx     = '0;
    // An exhausted owner is skipped so others get a turn.
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!rot && req[idx] && !(own_req && idx == owner)) begin
        rot  = 1'b1;
        rwin = idx;
      end
    end
    rot   = rot & ~cont;
    sole  = ~cont & ~rot & own_req;
    win_v = reset & (cont | rot | sole);
    unique case (1'b1)
      cont:    win = owner;
      rot:     win = rwin;
      sole:    win = owner;
      default: win = owner;
    endcase
    gnt = '0;
    if (win_v) gnt[win] = 1'b1;
    rf_rd_addr = win_v ? addr[win] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr    <= '0;
      owner  <= '0;
      own_v  <= 1'b0;
      cnt    <= '0;
      rdata  <= '0;
      rvalid <= '0;
      sel    <= '0;
    end else begin
      unique case (1'b1)
        cont: cnt <= cnt + 4'd1;
        rot: begin
          owner <= rwin;
          own_v <= 1'b1;
          cnt   <= '0;
          ptr   <= rwin + 2'd1;
        end
        sole: cnt <= '0;
        default: begin
          own_v <= 1'b0;
          cnt   <= '0;
        end
      endcase
      rvalid <= gnt;
      if (win_v) begin
        rdata <= rf_rd_data;
        sel   <= win;
      end
    end
  end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Bench for rf_read_arbiter: directed plan items plus random traffic
// compared against a burst/rotation reference model.
module tb_rf_read_arbiter;

  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      req;
  logic [3:0][4:0] addr;
  logic [3:0]      gnt;
  logic [4:0]      rf_rd_addr;
  logic [63:0]     rf_rd_data;
  logic [63:0]     rdata;
  logic [3:0]      rvalid;
  logic [1:0]      sel;

  logic [63:0] rf [32];
  assign rf_rd_data = rf[rf_rd_addr];

  always #5 clk = ~clk;

  rf_read_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .addr(addr),
    .gnt(gnt),
    .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data),
    .rdata(rdata),
    .rvalid(rvalid),
    .sel(sel)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // model: m_used = grants already given in the current burst
  int          m_ptr = 0;
  int          m_owner = -1;
  int          m_used = 0;
  logic [63:0] e_rdata = '0;
  logic [3:0]  e_rvalid = '0;
  logic [1:0]  e_sel = '0;
  logic [3:0]  g_last;

  function automatic int pick(input logic [3:0] r, output int kind);
    bit live;
    int c;
    live = (m_owner >= 0) ? r[m_owner[1:0]] : 1'b0;
    kind = 0;
    if (live && m_used < MB) begin
      kind = 1;
      return m_owner;
    end
    for (int k = 0; k < 4; k++) begin
      c = (m_ptr + k) % 4;
      if (r[c] && !(live && c == m_owner)) begin
        kind = 2;
        return c;
      end
    end
    if (live) begin
      kind = 3;
      return m_owner;
    end
    return -1;
  endfunction

  task automatic cycle(input logic rst, input logic [3:0] r,
                       input logic [3:0][4:0] a);
    int w;
    int kind;
    logic [3:0] eg;
    logic [4:0] ea;
    @(negedge clk);
    reset = rst;
    req = r;
    addr = a;
    #1;
    kind = 0;
    w = -1;
    if (rst) w = pick(r, kind);
    eg = (w >= 0) ? 4'(1 << w) : 4'b0;
    ea = (w >= 0) ? a[w] : 5'd0;
    g_last = gnt;
    check("gnt", 64'(gnt), 64'(eg));
    check("rf_rd_addr", 64'(rf_rd_addr), 64'(ea));
    @(posedge clk);
    #1;
    if (!rst) begin
      m_ptr = 0; m_owner = -1; m_used = 0;
      e_rdata = '0; e_rvalid = '0; e_sel = '0;
    end else begin
      case (kind)
        1: m_used++;
        2: begin m_owner = w; m_used = 1; m_ptr = (w + 1) % 4; end
        3: m_used = 1;
        default: begin m_owner = -1; m_used = 0; end
      endcase
      if (w >= 0) begin
        e_rdata = rf[ea];
        e_rvalid = eg;
        e_sel = 2'(w);
      end else e_rvalid = '0;
    end
    check("rdata", rdata, e_rdata);
    check("rvalid", 64'(rvalid), 64'(e_rvalid));
    check("sel", 64'(sel), 64'(e_sel));
  endtask

  logic [3:0][4:0] av;
  logic [3:0]      rq;
  logic            rs;

  initial begin
    reset = 1'b0;
    req = '0;
    addr = '0;
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
    rf[7] = 64'd256;

    // 1: reset then single request
    av = '0;
    av[2] = 5'd7;
    cycle(0, 4'b0000, av);
    cycle(0, 4'b0000, av);
    cycle(1, 4'b0100, av);
    check("t1_gnt", 64'(g_last), 64'h4);
    check("t1_rdata", rdata, 64'd256);
    check("t1_sel", 64'(sel), 64'h2);

    // 2: full contention
    cycle(0, 4'b0000, av);
    for (int i = 0; i < 16; i++) begin
      av = {5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom)};
      cycle(1, 4'b1111, av);
      check("t2_seq", 64'(g_last), 64'(1 << (i / 4)));
    end

    // 3: burst break and resume
    cycle(0, 4'b0000, av);
    for (int i = 0; i < 6; i++) begin
      rq = (i >= 2 && i <= 4) ? 4'b0011 : 4'b0001;
      cycle(1, rq, av);
      check("t3_seq", 64'(g_last), (i == 4) ? 64'h2 : 64'h1);
    end

    // 4: sole requester past burst limit
    cycle(0, 4'b0000, av);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 4'b1000, av);
      check("t4_gnt", 64'(g_last), 64'h8);
      check("t4_rvalid", 64'(rvalid), 64'h8);
    end

    // 5: idle gaps after a grant to 1
    cycle(0, 4'b0000, av);
    cycle(1, 4'b0010, av);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 4'b0000, av);
      check("t5_sel", 64'(sel), 64'h1);
    end
    cycle(1, 4'b1111, av);
    check("t5_next", 64'(g_last), 64'h4);

    // 6: reset mid-burst
    cycle(0, 4'b0000, av);
    cycle(1, 4'b0010, av);
    cycle(0, 4'b0010, av);
    check("t6_rdata", rdata, 64'h0);
    cycle(1, 4'b1111, av);
    check("t6_first", 64'(g_last), 64'h1);

    // random traffic
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(3) == 0) rq[b] = ~rq[b];
      rs = ($urandom_range(79) != 0);
      av = {5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom)};
      cycle(rs, rq, av);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
